// File: rtl/bram_sp_param.sv
// Single-port synchronous block RAM with selectable write mode, per-lane write
// enables, optional output register and a sequencer that fills the array with CLR_VAL.
module bram_sp_param #(
    parameter int                    DATA_WIDTH = 4,
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    WE_WIDTH   = 1,
    parameter string                 WRITE_MODE = "WRITE_FIRST",
    parameter int                    DO_REG     = 0,
    parameter logic [DATA_WIDTH-1:0] INIT       = '0,
    parameter logic [DATA_WIDTH-1:0] SRVAL      = '0,
    parameter logic [DATA_WIDTH-1:0] CLR_VAL    = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  REGCE,
    input  logic [WE_WIDTH-1:0]   WE,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic [DATA_WIDTH-1:0] DI,
    input  logic                  CLR,
    output logic                  BUSY,
    output logic [DATA_WIDTH-1:0] DO
);

    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam int LANE_W  = DATA_WIDTH / WE_WIDTH;
    localparam bit MODE_RF = (WRITE_MODE == "READ_FIRST");
    localparam bit MODE_NC = (WRITE_MODE == "NO_CHANGE");

    typedef enum logic {
        ST_IDLE,
        ST_FILL
    } state_t;

    // NOTE: the array has no reset; only its power-up image is defined, so
    // RST never disturbs stored words and the array maps onto block RAM.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    state_t                state_q = ST_IDLE;
    state_t                state_d;
    logic [ADDR_WIDTH:0]   cnt_q   = '0;
    logic [ADDR_WIDTH:0]   cnt_d;
    logic [DATA_WIDTH-1:0] latch_q = INIT;
    logic [DATA_WIDTH-1:0] latch_d;
    logic [DATA_WIDTH-1:0] oreg_q  = INIT;
    logic [DATA_WIDTH-1:0] oreg_d;

    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] wr_word;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // NOTE: every signal gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_word = mem_q[ADDR];
        wr_word = rd_word;
        for (int l = 0; l < WE_WIDTH; l++) begin
            if (WE[l]) begin
                wr_word[l*LANE_W +: LANE_W] = DI[l*LANE_W +: LANE_W];
            end
        end

        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_d   = latch_q;
        oreg_d    = oreg_q;
        mem_we    = 1'b0;
        mem_addr  = ADDR;
        mem_wdata = wr_word;

        case (state_q)
            ST_IDLE: begin
                if (EN) begin
                    if (|WE) begin
                        mem_we = 1'b1;
                        if (MODE_RF) begin
                            latch_d = rd_word;
                        end else if (!MODE_NC) begin
                            latch_d = wr_word;
                        end
                    end else begin
                        latch_d = rd_word;
                    end
                end
                if ((DO_REG != 0) && REGCE) begin
                    oreg_d = latch_q;
                end
                // The user access at this edge still completes; the fill begins next edge.
                if (CLR) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                end
            end
            ST_FILL: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q[ADDR_WIDTH-1:0];
                mem_wdata = CLR_VAL;
                cnt_d     = cnt_q + 1'b1;
                // The extra counter bit flags the write of the last address.
                if (cnt_d[ADDR_WIDTH]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (RST) begin
            mem_we = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            latch_q <= SRVAL;
            oreg_q  <= SRVAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
            oreg_q  <= oreg_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    assign BUSY = (state_q == ST_FILL);
    assign DO   = (DO_REG != 0) ? oreg_q : latch_q;

endmodule
